imm_splitter: RTL



---
 rtl/imm_splitter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/imm_splitter.sv
// ---------------------------------------------------------------------------
// imm_splitter
//
// Turns a 32-bit constant into the 16-bit immediate beat(s) needed to rebuild
// it. This is the inverse of the immediate sign/zero extender.
//   - Constants that fit a single immediate produce one beat:
//       kind 00 (signed, addi-style) or kind 01 (zero-extended, ori-style).
//   - All other constants produce two beats:
//       kind 10 (upper half, lui-style), then kind 11 (lower half, ori-style).
// Both sides use valid/ready handshakes. A constant that fits is presented on
// the cycle after it is accepted, so fitting constants stream one per cycle.
//
// Parameters:
//   ALWAYS_SPLIT  1 = emit every constant as an upper/lower pair.
//
// Optional feature (macro IMM_SPLITTER_STATS_EN):
//   Adds split_cnt_o, a saturating count of accepted constants that needed
//   two beats. Cleared by rst_i.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous, active-high reset
//   data_i       constant to encode
//   select_i     1 = signed extension target, 0 = zero extension target
//   valid_i      data_i/select_i valid
//   ready_o      block accepts an input this cycle
//   imm_o        immediate field of the current output beat
//   kind_o       00 single signed, 01 single zero, 10 upper, 11 lower
//   last_o       current beat is the final beat of its constant
//   valid_o      output beat valid
//   ready_i      downstream accepts the beat
//   split_cnt_o  (IMM_SPLITTER_STATS_EN only) count of split constants
// ---------------------------------------------------------------------------
module imm_splitter #(
  parameter bit ALWAYS_SPLIT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        select_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [15:0] imm_o,
  output logic [1:0]  kind_o,
  output logic        last_o,
  output logic        valid_o,
  input  logic        ready_i
`ifdef IMM_SPLITTER_STATS_EN
  ,
  output logic [15:0] split_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    HI     = 2'd2,
    LO     = 2'd3
  } state_t;

  localparam logic [1:0] KIND_HI = 2'b10;
  localparam logic [1:0] KIND_LO = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] imm_q,   imm_d;
  logic [1:0]  kind_q,  kind_d;
  logic        last_q,  last_d;
  logic [15:0] lo_q,    lo_d;   // lower half waiting behind an upper beat

  logic accept;
  logic fits;

  // A new constant can enter when nothing is held, or when the beat being
  // presented is a final one and leaves this cycle. HI never accepts because
  // its lower half still has to go out.
  assign ready_o = (state_q == IDLE) ||
                   (((state_q == SINGLE) || (state_q == LO)) && ready_i);
  assign accept  = valid_i && ready_o;

  always_comb begin
    if (select_i) fits = (data_i[31:16] == {16{data_i[15]}});
    else          fits = (data_i[31:16] == 16'h0000);
    if (ALWAYS_SPLIT) fits = 1'b0;
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    kind_d  = kind_q;
    last_d  = last_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE, SINGLE, LO: begin
        if (accept) begin
          if (fits) begin
            state_d = SINGLE;
            imm_d   = data_i[15:0];
            kind_d  = {1'b0, ~select_i};
            last_d  = 1'b1;
          end else begin
            state_d = HI;
            imm_d   = data_i[31:16];
            kind_d  = KIND_HI;
            last_d  = 1'b0;
            lo_d    = data_i[15:0];
          end
        end else if ((state_q != IDLE) && ready_i) begin
          state_d = IDLE;
        end
      end
      HI: begin
        if (ready_i) begin
          state_d = LO;
          imm_d   = lo_q;
          kind_d  = KIND_LO;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      imm_q   <= '0;
      kind_q  <= '0;
      last_q  <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      kind_q  <= kind_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
    end
  end

  assign valid_o = (state_q != IDLE);
  assign imm_o   = imm_q;
  assign kind_o  = kind_q;
  assign last_o  = last_q;

`ifdef IMM_SPLITTER_STATS_EN
  logic [15:0] split_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      split_cnt_q <= '0;
    end else if (accept && !fits && (split_cnt_q != 16'hFFFF)) begin
      split_cnt_q <= split_cnt_q + 16'd1;
    end
  end

  assign split_cnt_o = split_cnt_q;
`endif

endmodule
